gpio_irq: RTL and testbench
===========================

# gpio_irq

Edge-detect and interrupt-pending block sitting directly downstream of the GPIO port. It consumes the GPIO block's registered pin-input word (`o_DIN`), detects per-pin rising, falling or both-edge events, and latches them into a sticky pending register. It drives a single level interrupt request to the MIPS core. Its configuration and pending registers are memory-mapped on the same data bus that feeds the GPIO's write data.

## Interface
- `WIDTH`, default 32: number of GPIO pins and width of every register.
- `i_Clk`  input  1  system clock; all state updates on the rising edge.
- `i_rst_n`  input  1  reset, asynchronous assert, active-low.
- `i_DIN`  input  WIDTH  sampled pin levels, wired from the GPIO `o_DIN`.
- `i_DD`  input  WIDTH  bus write data.
- `i_Addr`  input  2  register select: 0 IE, 1 EDGE, 2 BOTH, 3 PEND.
- `i_WE`  input  1  write strobe; one write per cycle where high.
- `o_RD`  output  WIDTH  read data for the register at `i_Addr`, combinational from flops.
- `o_IRQ`  output  1  interrupt request, level, active-high.

## Operation
- Registers, all reset to 0:
  - IE: per-pin enable.
  - EDGE: 1 = rising, 0 = falling.
  - BOTH: 1 = any edge, overrides EDGE.
  - PEND: sticky pending.
  - PREV: last sample of `i_DIN`.
  - ARMED: 1-bit.
- Writes to addresses 0–2 (`i_WE`=1) load `i_DD` into IE, EDGE or BOTH respectively.
- Write to address 3 is write-1-to-clear: `PEND <= (PEND & ~i_DD) | set`.
- PREV loads `i_DIN` every cycle.
- ARMED goes to 1 on the first clock after reset release and stays 1. While ARMED=0, no edges are detected. This prevents pins already high at reset release from raising spurious rising events.
- Per bit i, the event condition is ARMED & IE[i] & (cur != PREV[i]) & (BOTH[i] | (EDGE[i] ? cur : ~cur)), where cur = `i_DIN[i]`. When it is true, `set[i]`=1.
- PEND[i] stays set until cleared by a W1C write. Further events on a pending bit have no additional effect; there is no counting.
- Clearing IE[i] does not clear PEND[i]. It only masks new events and masks that bit from `o_IRQ`.
- `o_IRQ` = |(PEND & IE), computed combinationally from flops, so it is glitch-free with respect to the bus.
- `o_RD` returns IE, EDGE, BOTH or PEND by `i_Addr`. Reading has no side effects.

## Timing
- Edge latency:
  - `i_DIN` changes before edge k; the event is evaluated against PREV at edge k.
  - PEND[i] is 1 after edge k.
  - `o_IRQ` is high in the same cycle.
- W1C latency: a clear write at edge k leaves PEND[i]=0 after edge k, and `o_IRQ` drops that cycle if no other bit is enabled and pending.
- Simultaneous events in the same edge:
  - W1C on a bit and a new event on that bit: set wins, so PEND stays 1.
  - Config write (IE/EDGE/BOTH) and a pin event: detection uses the pre-write config. The new config takes effect from the next edge.
  - Multiple pins changing: all qualifying bits are set together.
- A pulse on `i_DIN` shorter than one clock is not guaranteed to be seen. `i_DIN` is already synchronous, being registered in GPIO, so no extra synchronizer is needed.
- Reset mid-operation clears all registers and ARMED immediately and asynchronously, so `o_IRQ`=0 at once. The first clock after release only primes PREV.

## Structure
- The shared header `gpio_defs` holds the register address constants (ADDR_IE=0, ADDR_EDGE=1, ADDR_BOTH=2, ADDR_PEND=3) and the default WIDTH. The GPIO bus decoder uses the same file.
- One sub-module is natural: `gpio_edge_cell`, a per-bit detect plus PEND flop, instantiated WIDTH times via generate.
- The top level holds the config registers, ARMED, the read mux and the IRQ reduction.

## Test plan
- Reset priming: hold `i_DIN`=32'hFFFF_FFFF through reset with IE=all-ones written, EDGE=all-ones. Required: PEND=0 and `o_IRQ`=0 indefinitely.
- Rising edge: IE=32'h1, EDGE=32'h1; `i_DIN[0]` 0→1. Required: PEND=32'h1 and `o_IRQ`=1 one edge later. Then write 32'h1 to address 3. Required: PEND=0 and `o_IRQ`=0 after that edge.
- Falling/both: IE=32'h6, EDGE=0, BOTH=32'h4; toggle bits 1 and 2 0→1→0. Required: bit 1 sets only on the 1→0 transition; bit 2 sets on the first (0→1) transition; final PEND=32'h6.
- Masking: IE=0, toggle `i_DIN[3]`. Required: PEND stays 0. With PEND[5]=1, write IE[5]=0. Required: `o_IRQ`=0 and reading PEND returns 32'h20.
- Set-vs-clear collision: PEND[7]=1, then in the same cycle write 32'h80 to address 3 while `i_DIN[7]` rises with IE[7]=EDGE[7]=1. Required: PEND[7]=1 afterwards.
- Async reset mid-operation: with PEND=32'hF0 and `o_IRQ`=1, pulse `i_rst_n` low between clock edges. Required: `o_IRQ`=0 and all reads return 0 before the next edge.

Source files
------------

// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the GPIO interrupt block and the GPIO bus decoder.
//   DefWidth : default number of GPIO pins / register width
//   addr_e   : register select encoding on the 2-bit bus address
package gpio_irq_pkg;

   localparam int unsigned DefWidth = 32;

   typedef enum logic [1:0] {
      AddrIe   = 2'd0,
      AddrEdge = 2'd1,
      AddrBoth = 2'd2,
      AddrPend = 2'd3
   } addr_e;

endpackage

// File: rtl/gpio_irq_if.sv
// Register bus between the GPIO bus decoder (master) and gpio_irq (slave).
//   wdata : write data (shared with the GPIO write data)
//   addr  : register select, see gpio_irq_pkg::addr_e
//   we    : write strobe, one write per cycle while high
//   rdata : read data of the selected register
interface gpio_irq_if
   import gpio_irq_pkg::*;
#(
   parameter int unsigned Width = DefWidth
) ();

   logic [Width-1:0] wdata;
   logic [1:0]       addr;
   logic             we;
   logic [Width-1:0] rdata;

   modport master (output wdata, output addr, output we, input rdata);
   modport slave  (input wdata, input addr, input we, output rdata);

endinterface

// File: rtl/gpio_irq_edge_cell.sv
// One pin of the interrupt block: edge detection against the previous sample
// plus the sticky pending flop.
//   clk, rst_n : clock, asynchronous active-low reset
//   armed      : detection enable, low until the first clock after reset
//   ie         : pin interrupt enable (masks new events only)
//   rise_sel   : 1 = rising edge, 0 = falling edge
//   both       : 1 = any edge, overrides rise_sel
//   cur        : current pin level (already synchronous)
//   clr        : write-1-to-clear strobe for this bit
//   pend       : sticky pending flag
module gpio_irq_edge_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic armed,
   input  logic ie,
   input  logic rise_sel,
   input  logic both,
   input  logic cur,
   input  logic clr,
   output logic pend
);

   logic prev_q;
   logic pend_q, pend_d;
   logic set;

   always_comb begin
      set    = armed & ie & (cur ^ prev_q) & (both | (rise_sel ? cur : ~cur));
      // A new event beats a simultaneous clear.
      pend_d = (pend_q & ~clr) | set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         prev_q <= cur;
         pend_q <= pend_d;
      end
   end

   assign pend = pend_q;

endmodule

// File: rtl/gpio_irq.sv
// GPIO edge-detect and interrupt-pending block.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : registered pin levels from the GPIO block
//   bus        : register bus (IE / EDGE / BOTH / PEND), slave side
//   irq        : level interrupt request, |(PEND & IE)
module gpio_irq
   import gpio_irq_pkg::*;
#(
   parameter int unsigned Width = DefWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [Width-1:0] din,
   gpio_irq_if.slave        bus,
   output logic             irq
);

   logic [Width-1:0] ie_q;
   logic [Width-1:0] edge_q;
   logic [Width-1:0] both_q;
   logic [Width-1:0] pend;
   logic [Width-1:0] clr;
   logic             armed_q;
   addr_e            addr;

   assign addr = addr_e'(bus.addr);

   // Config and ARMED; ARMED keeps the first post-reset clock from seeing
   // pins that were already high as rising edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ie_q    <= '0;
         edge_q  <= '0;
         both_q  <= '0;
         armed_q <= 1'b0;
      end else begin
         armed_q <= 1'b1;
         if (bus.we) begin
            unique case (addr)
               AddrIe:   ie_q   <= bus.wdata;
               AddrEdge: edge_q <= bus.wdata;
               AddrBoth: both_q <= bus.wdata;
               AddrPend: ;
            endcase
         end
      end
   end

   assign clr = (bus.we && (addr == AddrPend)) ? bus.wdata : '0;

   for (genvar i = 0; i < Width; i++) begin : g_cell
      gpio_irq_edge_cell u_cell (
         .clk      (clk),
         .rst_n    (rst_n),
         .armed    (armed_q),
         .ie       (ie_q[i]),
         .rise_sel (edge_q[i]),
         .both     (both_q[i]),
         .cur      (din[i]),
         .clr      (clr[i]),
         .pend     (pend[i])
      );
   end

   always_comb begin
      bus.rdata = '0;
      unique case (addr)
         AddrIe:   bus.rdata = ie_q;
         AddrEdge: bus.rdata = edge_q;
         AddrBoth: bus.rdata = both_q;
         AddrPend: bus.rdata = pend;
      endcase
   end

   assign irq = |(pend & ie_q);

endmodule

// File: tb/tb_gpio_irq.sv
module tb_gpio_irq;
   import gpio_irq_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] din;
   logic        irq;

   gpio_irq_if #(.Width(32)) bus ();

   gpio_irq #(.Width(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din),
      .bus   (bus),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] m_ie, m_edge, m_both, m_pend, m_prev;
   bit          m_armed;

   task automatic model_reset();
      m_ie = '0; m_edge = '0; m_both = '0; m_pend = '0; m_prev = '0; m_armed = 1'b0;
   endtask

   function automatic logic [31:0] model_reg(input logic [1:0] a);
      case (a)
         2'd0:    return m_ie;
         2'd1:    return m_edge;
         2'd2:    return m_both;
         default: return m_pend;
      endcase
   endfunction

   // Advance the model by one clock edge using the pre-edge state.
   task automatic model_clock(input logic [31:0] d, input logic w, input logic [1:0] a,
                              input logic [31:0] dd);
      logic [31:0] rise, fall, want, clr;
      rise = d & ~m_prev;
      fall = ~d & m_prev;
      want = (rise & (m_both | m_edge)) | (fall & (m_both | ~m_edge));
      clr  = (w && a == 2'd3) ? dd : 32'h0;
      m_pend = (m_pend & ~clr) | (m_armed ? (m_ie & want) : 32'h0);
      if (w) begin
         if (a == 2'd0) m_ie = dd;
         if (a == 2'd1) m_edge = dd;
         if (a == 2'd2) m_both = dd;
      end
      m_prev  = d;
      m_armed = 1'b1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
      bus.we   = 1'b0;
      bus.addr = a;
      #1;
      check(tag, bus.rdata, exp);
   endtask

   // Drive one cycle, clock it, then compare PEND and IRQ against the model.
   task automatic step(input logic [31:0] d, input logic w, input logic [1:0] a,
                       input logic [31:0] dd);
      din       = d;
      bus.we    = w;
      bus.addr  = a;
      bus.wdata = dd;
      model_clock(d, w, a, dd);
      @(posedge clk);
      #1;
      read_check("pend", 2'd3, m_pend);
      check("irq", {31'h0, irq}, {31'h0, |(m_pend & m_ie)});
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  a;
      logic        w;
      logic [31:0] dd;

      rst_n     = 1'b0;
      din       = 32'hFFFF_FFFF;
      bus.we    = 1'b0;
      bus.addr  = 2'd0;
      bus.wdata = '0;
      model_reset();

      // Registers read zero while in reset
      #12;
      for (int i = 0; i < 4; i++) read_check("reset_rd", 2'(i), 32'h0);
      check("reset_irq", {31'h0, irq}, 32'h0);
      #5 rst_n = 1'b1;

      // Pins held high through reset must not register as rising edges
      step(32'hFFFF_FFFF, 1'b1, AddrIe, 32'hFFFF_FFFF);
      step(32'hFFFF_FFFF, 1'b1, AddrEdge, 32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++) step(32'hFFFF_FFFF, 1'b0, AddrIe, 32'h0);
      read_check("prime_pend", 2'd3, 32'h0);

      // Rising edge on bit 0, then W1C
      step(32'h0, 1'b1, AddrIe, 32'h1);
      step(32'h0, 1'b1, AddrEdge, 32'h1);
      step(32'h1, 1'b0, AddrIe, 32'h0);
      read_check("rise_pend", 2'd3, 32'h1);
      check("rise_irq", {31'h0, irq}, 32'h1);
      step(32'h1, 1'b1, AddrPend, 32'h1);
      read_check("w1c_pend", 2'd3, 32'h0);
      check("w1c_irq", {31'h0, irq}, 32'h0);

      // Falling on bit 1, both on bit 2
      step(32'h0, 1'b1, AddrIe, 32'h6);
      step(32'h0, 1'b1, AddrEdge, 32'h0);
      step(32'h0, 1'b1, AddrBoth, 32'h4);
      step(32'h6, 1'b0, AddrIe, 32'h0);
      read_check("both_rise", 2'd3, 32'h4);
      step(32'h0, 1'b0, AddrIe, 32'h0);
      read_check("fall_pend", 2'd3, 32'h6);
      step(32'h0, 1'b1, AddrPend, 32'h6);

      // Masking
      step(32'h0, 1'b1, AddrIe, 32'h0);
      step(32'h8, 1'b0, AddrIe, 32'h0);
      step(32'h0, 1'b0, AddrIe, 32'h0);
      read_check("mask_pend", 2'd3, 32'h0);
      step(32'h0, 1'b1, AddrIe, 32'h20);
      step(32'h0, 1'b1, AddrEdge, 32'h20);
      step(32'h20, 1'b0, AddrIe, 32'h0);
      check("p5_irq", {31'h0, irq}, 32'h1);
      step(32'h20, 1'b1, AddrIe, 32'h0);
      check("mask_irq", {31'h0, irq}, 32'h0);
      read_check("mask_keep", 2'd3, 32'h20);
      step(32'h0, 1'b1, AddrPend, 32'hFFFF_FFFF);

      // Set beats simultaneous clear
      step(32'h0, 1'b1, AddrIe, 32'h80);
      step(32'h0, 1'b1, AddrEdge, 32'h80);
      step(32'h80, 1'b0, AddrIe, 32'h0);
      step(32'h0, 1'b0, AddrIe, 32'h0);
      step(32'h80, 1'b1, AddrPend, 32'h80);
      read_check("collide", 2'd3, 32'h80);

      // Asynchronous reset between edges
      step(32'h0, 1'b1, AddrPend, 32'hFFFF_FFFF);
      step(32'h0, 1'b1, AddrIe, 32'hFF);
      step(32'h0, 1'b1, AddrEdge, 32'hFF);
      step(32'hF0, 1'b0, AddrIe, 32'h0);
      read_check("pre_rst_pend", 2'd3, 32'hF0);
      check("pre_rst_irq", {31'h0, irq}, 32'h1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_irq", {31'h0, irq}, 32'h0);
      for (int i = 0; i < 4; i++) read_check("async_rd", 2'(i), 32'h0);
      rst_n = 1'b1;

      // Randomized traffic against the model
      d = 32'hF0;
      for (int n = 0; n < 400; n++) begin
         d  = d ^ ($urandom & $urandom & $urandom);
         w  = 1'($urandom_range(0, 2) != 0);
         a  = 2'($urandom_range(0, 3));
         dd = (a == 2'd3) ? ($urandom & $urandom) : $urandom;
         step(d, w, a, dd);
         a = 2'($urandom_range(0, 3));
         read_check("rand_rd", a, model_reg(a));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
